// File: rtl/fadd_arbiter_if.sv
// Request / adder / result bundle for fadd_arbiter.
// master: requesters, adder and result consumer.  slave: the arbiter itself.
interface fadd_arbiter_if #(
    parameter int FLEN = 32,
    parameter int TAGW = 5
);
    localparam int NEXP     = (FLEN == 64) ? 11 : 8;
    localparam int NSIG     = (FLEN == 64) ? 52 : 23;
    localparam int NFULLSIG = 2 * NSIG + 1;
    localparam int OPW      = FLEN + (NEXP + 3) + (NFULLSIG + 1) + 6;

    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [2*OPW-1:0]  req_a_i;
    logic [2*OPW-1:0]  req_b_i;
    logic [5:0]        req_rm_i;
    logic [1:0]        req_sub_i;
    logic [2*TAGW-1:0] req_tag_i;

    logic [OPW-1:0]    add_rs1_o;
    logic [OPW-1:0]    add_rs2_o;
    logic [2:0]        add_rm_o;
    logic [FLEN-1:0]   add_res_i;

    logic              res_valid_o;
    logic              res_ready_i;
    logic [FLEN-1:0]   res_data_o;
    logic              res_id_o;
    logic [TAGW-1:0]   res_tag_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_rm_i, req_sub_i, req_tag_i,
        output add_res_i, res_ready_i,
        input  req_ready_o, add_rs1_o, add_rs2_o, add_rm_o,
        input  res_valid_o, res_data_o, res_id_o, res_tag_o
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_rm_i, req_sub_i, req_tag_i,
        input  add_res_i, res_ready_i,
        output req_ready_o, add_rs1_o, add_rs2_o, add_rm_o,
        output res_valid_o, res_data_o, res_id_o, res_tag_o
    );
endinterface

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: shares one combinational FP adder between FADD/FSUB issue (req0)
// and FMA post-multiply (req1). Applies the subtract sign flip on rs2 and
// registers the adder result together with requester id and tag.
// Build option: FADD_ARB_FMA_PRIO_EN -> req1 always wins a tie (no round-robin).
module fadd_arbiter #(
    parameter int FLEN = 32,
    parameter int TAGW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fadd_arbiter_if.slave bus
);
    localparam int NEXP     = (FLEN == 64) ? 11 : 8;
    localparam int NSIG     = (FLEN == 64) ? 52 : 23;
    localparam int NFULLSIG = 2 * NSIG + 1;
    localparam int OPW      = FLEN + (NEXP + 3) + (NFULLSIG + 1) + 6;

    logic [1:0]      grant;
    logic            sel;
    logic            slot_free;
    logic            accept;
    logic [OPW-1:0]  rs2_sel;

    logic            res_valid_q;
    logic [FLEN-1:0] res_data_q;
    logic            res_id_q;
    logic [TAGW-1:0] res_tag_q;

`ifndef FADD_ARB_FMA_PRIO_EN
    logic            rr_last;
`endif

    // Pick the winner among valid requesters; computed even while stalled so it stays stable.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        grant = 2'b00;
        case (bus.req_valid_i)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
`ifdef FADD_ARB_FMA_PRIO_EN
                grant = 2'b10;
`else
                grant = rr_last ? 2'b01 : 2'b10;
`endif
            end
            default: grant = 2'b00;
        endcase
    end

    assign sel         = grant[1];
    assign slot_free   = !res_valid_q || bus.res_ready_i;
    assign bus.req_ready_o = (slot_free && !rst_i) ? grant : 2'b00;
    assign accept      = |bus.req_ready_o;

    // Route the selected requester to the adder; subtract flips only the rs2 raw sign bit.
    always_comb begin
        rs2_sel          = sel ? bus.req_b_i[OPW +: OPW] : bus.req_b_i[0 +: OPW];
        rs2_sel[OPW-1]   = rs2_sel[OPW-1] ^ bus.req_sub_i[sel];
        bus.add_rs1_o    = sel ? bus.req_a_i[OPW +: OPW] : bus.req_a_i[0 +: OPW];
        bus.add_rs2_o    = rs2_sel;
        bus.add_rm_o     = sel ? bus.req_rm_i[5:3] : bus.req_rm_i[2:0];
    end

`ifndef FADD_ARB_FMA_PRIO_EN
    // Remember the last accepted requester; idle and stalled cycles leave it alone.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values.
        if (rst_i) begin
            rr_last <= 1'b1;
        end else if (accept) begin
            rr_last <= sel;
        end
    end
`endif

    // Result register: load on accept, else drop valid when consumed; data/id/tag hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_tag_q   <= '0;
        end else if (accept) begin
            res_valid_q <= 1'b1;
            res_data_q  <= bus.add_res_i;
            res_id_q    <= sel;
            res_tag_q   <= sel ? bus.req_tag_i[TAGW +: TAGW] : bus.req_tag_i[0 +: TAGW];
        end else if (bus.res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.res_valid_o = res_valid_q;
    assign bus.res_data_o  = res_data_q;
    assign bus.res_id_o    = res_id_q;
    assign bus.res_tag_o   = res_tag_q;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Testbench for fadd_arbiter (FLEN=32): directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_fadd_arbiter;
    localparam int FLEN = 32;
    localparam int TAGW = 5;
    localparam int OPW  = 32 + 11 + 48 + 6;
    localparam int XW   = OPW - FLEN;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fadd_arbiter_if #(.FLEN(FLEN), .TAGW(TAGW)) bus ();
    fadd_arbiter #(.FLEN(FLEN), .TAGW(TAGW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    // ---------------- fake single-precision adder (normals, zero, NaN/Inf) ----------------
    function automatic real f2r(input logic [31:0] a);
        logic [63:0] d;
        if (a[30:23] == 8'h00) return 0.0;
        d = {a[31], 11'(int'(a[30:23]) - 127 + 1023), a[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fadd32(input logic [31:0] a, input logic [31:0] b);
        real         rs;
        logic [63:0] bits;
        int          e;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
        rs = f2r(a) + f2r(b);
        if (rs == 0.0) return 32'h0;
        bits = $realtobits(rs);
        e = int'(bits[62:52]) - 1023 + 127;
        if (e >= 255) return {bits[63], 8'hFF, 23'h0};
        if (e <= 0) return {bits[63], 31'h0};
        return {bits[63], e[7:0], bits[51:29]};
    endfunction

    assign bus.add_res_i = fadd32(bus.add_rs1_o[OPW-1 -: FLEN], bus.add_rs2_o[OPW-1 -: FLEN]);

    // ---------------- requester stimulus ----------------
    logic [31:0]     raw_a [2];
    logic [31:0]     raw_b [2];
    logic [XW-1:0]   ext_a [2];
    logic [XW-1:0]   ext_b [2];
    logic [2:0]      rm    [2];
    logic [TAGW-1:0] tag   [2];
    logic [1:0]      valid;
    logic [1:0]      sub;
    logic            res_ready;

    // ---------------- reference model (transaction level) ----------------
    logic            m_valid;
    logic [31:0]     m_data;
    logic            m_id;
    logic [TAGW-1:0] m_tag;
    int              m_last;     // index of the last requester that won a transfer
    logic [1:0]      m_acc;      // predicted accept mask of the cycle just checked

    logic [1:0]      cap_ready;
    logic [31:0]     cap_rs2raw;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 1'b0;
        m_tag   = '0;
        m_last  = 1;
    endtask

    function automatic int winner();
        if (valid == 2'b00) return -1;
        if (valid == 2'b01) return 0;
        if (valid == 2'b10) return 1;
`ifdef FADD_ARB_FMA_PRIO_EN
        return 1;
`else
        return 1 - m_last;
`endif
    endfunction

    task automatic drive();
        bus.req_valid_i = valid;
        bus.req_a_i     = {raw_a[1], ext_a[1], raw_a[0], ext_a[0]};
        bus.req_b_i     = {raw_b[1], ext_b[1], raw_b[0], ext_b[0]};
        bus.req_rm_i    = {rm[1], rm[0]};
        bus.req_sub_i   = sub;
        bus.req_tag_i   = {tag[1], tag[0]};
        bus.res_ready_i = res_ready;
    endtask

    // Compare every DUT output with the model at the falling edge, then advance the model.
    task automatic check_cycle();
        int         w;
        int         w0;
        bit         free;
        logic [1:0] er;
        logic [31:0] b_eff;
        w    = winner();
        w0   = (w < 0) ? 0 : w;
        free = !m_valid || res_ready;
        er   = (free && !rst && w >= 0) ? 2'(1 << w) : 2'b00;
        b_eff = sub[w0] ? (raw_b[w0] ^ 32'h8000_0000) : raw_b[w0];
        cap_ready  = bus.req_ready_o;
        cap_rs2raw = bus.add_rs2_o[OPW-1 -: FLEN];
        chk("req_ready", bus.req_ready_o, er);
        chk("add_rs1",   bus.add_rs1_o, {raw_a[w0], ext_a[w0]});
        chk("add_rs2",   bus.add_rs2_o, {b_eff, ext_b[w0]});
        chk("add_rm",    bus.add_rm_o, rm[w0]);
        chk("res_valid", bus.res_valid_o, m_valid);
        chk("res_data",  bus.res_data_o, m_data);
        chk("res_id",    bus.res_id_o, m_id);
        chk("res_tag",   bus.res_tag_o, m_tag);
        m_acc = er;
        if (rst) begin
            model_reset();
        end else if (er != 2'b00) begin
            m_valid = 1'b1;
            m_data  = fadd32(raw_a[w], b_eff);
            m_id    = 1'(w);
            m_tag   = tag[w];
            m_last  = w;
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_float();
        if ($urandom_range(0, 15) == 0) return 32'h7FC00000;
        return {1'($urandom), 8'(110 + $urandom_range(0, 30)), 23'($urandom)};
    endfunction

    task automatic new_req(input int n);
        valid[n] = ($urandom_range(0, 3) != 0);
        raw_a[n] = rand_float();
        raw_b[n] = rand_float();
        ext_a[n] = XW'({$urandom, $urandom, $urandom});
        ext_b[n] = XW'({$urandom, $urandom, $urandom});
        rm[n]    = 3'($urandom);
        tag[n]   = TAGW'($urandom);
        sub[n]   = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        logic [1:0]  exp_seq [4];

        model_reset();
        valid = 2'b00; sub = 2'b00; res_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            raw_a[n] = '0; raw_b[n] = '0; ext_a[n] = '0; ext_b[n] = '0;
            rm[n] = '0; tag[n] = '0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_valid", bus.res_valid_o, 1'b0);
        chk("reset_data",  bus.res_data_o, 32'h0);

        // 1) req0 only: 1.0 + 2.0
        valid = 2'b01; raw_a[0] = 32'h3F800000; raw_b[0] = 32'h40000000; sub[0] = 1'b0; tag[0] = 5'd3;
        step();
        chk("t1_ready", cap_ready, 2'b01);
        valid = 2'b00;
        chk("t1_valid", bus.res_valid_o, 1'b1);
        chk("t1_data",  bus.res_data_o, 32'h40400000);
        chk("t1_id",    bus.res_id_o, 1'b0);
        chk("t1_tag",   bus.res_tag_o, 5'd3);

        // 2) req0 subtract: 3.0 - 1.0
        valid = 2'b01; raw_a[0] = 32'h40400000; raw_b[0] = 32'h3F800000; sub[0] = 1'b1;
        step();
        chk("t2_rs2raw", cap_rs2raw, 32'hBF800000);
        chk("t2_data",   bus.res_data_o, 32'h40000000);
        valid = 2'b00; sub[0] = 1'b0;
        step();

        // 3) both valid for 4 accepting cycles right after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef FADD_ARB_FMA_PRIO_EN
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10};
`else
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        valid = 2'b11; res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            raw_a[0] = rand_float(); raw_b[0] = rand_float();
            raw_a[1] = rand_float(); raw_b[1] = rand_float();
            step();
            chk("t3_grant", cap_ready, exp_seq[i]);
            chk("t3_id",    bus.res_id_o, exp_seq[i][1]);
            chk("t3_valid", bus.res_valid_o, 1'b1);
        end

        // 4) result pending, consumer stalls 3 cycles while req1 waits
        valid = 2'b10; res_ready = 1'b0;
        raw_a[1] = 32'h3F800000; raw_b[1] = 32'h3F800000; sub[1] = 1'b0; tag[1] = 5'd17;
        held = bus.res_data_o;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stall_ready", cap_ready, 2'b00);
            chk("t4_stall_data",  bus.res_data_o, held);
        end
        res_ready = 1'b1;
        step();
        chk("t4_accept", cap_ready, 2'b10);
        chk("t4_data",   bus.res_data_o, 32'h40000000);
        chk("t4_tag",    bus.res_tag_o, 5'd17);

        // 5) req0 accepted, then reset before the result is consumed
        valid = 2'b01; res_ready = 1'b1; raw_a[0] = 32'h3F800000; raw_b[0] = 32'h40000000; sub[0] = 1'b0;
        step();
        valid = 2'b00; res_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", bus.res_valid_o, 1'b0);
        chk("t5_data",  bus.res_data_o, 32'h0);
        chk("t5_id",    bus.res_id_o, 1'b0);
        chk("t5_tag",   bus.res_tag_o, 5'd0);
        valid = 2'b11; res_ready = 1'b1;
        step();
`ifdef FADD_ARB_FMA_PRIO_EN
        chk("t5_tie", cap_ready, 2'b10);
`else
        chk("t5_tie", cap_ready, 2'b01);
`endif

        // 6) req1 subtract with a quiet NaN on rs2
        valid = 2'b10; raw_a[1] = 32'h3F800000; raw_b[1] = 32'h7FC00000; sub[1] = 1'b1;
        step();
        chk("t6_rs2raw", cap_rs2raw, 32'hFFC00000);
        chk("t6_data",   bus.res_data_o, 32'h7FC00000);
        chk("t6_id",     bus.res_id_o, 1'b1);

        // Randomized traffic; a requester holds its request until the model says it was taken.
        valid = 2'b00;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (rst || !valid[n] || m_acc[n]) new_req(n);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
